// File: rtl/bayer_capture_ctrl.sv
// Frame-aligned capture sequencer: arm/align, crop, 1-of-N decimation, frame drop on back-pressure.
// Optional build macro BAYER_CAPTURE_TEST_PATTERN_EN adds cfg_pattern (coordinate test pattern on out_data).
module bayer_capture_ctrl #(
    parameter int DW  = 12,
    parameter int CW  = 12,
    parameter int FCW = 16
) (
    input  logic           CAMERA_PIXCLK,
    input  logic           reset_n,
    input  logic           CAMERA_FVAL,
    input  logic [CW-1:0]  bayer_x,
    input  logic [CW-1:0]  bayer_y,
    input  logic [DW-1:0]  bayer_data,
    input  logic           bayer_valid,
    input  logic           cfg_start,
    input  logic           cfg_stop,
    input  logic           cfg_single,
    input  logic [3:0]     cfg_skip,
    input  logic [CW-1:0]  cfg_x_start,
    input  logic [CW-1:0]  cfg_y_start,
    input  logic [CW-1:0]  cfg_width,
    input  logic [CW-1:0]  cfg_height,
`ifdef BAYER_CAPTURE_TEST_PATTERN_EN
    input  logic           cfg_pattern,
`endif
    input  logic           fifo_afull,
    output logic [DW-1:0]  out_data,
    output logic           out_valid,
    output logic           out_sof,
    output logic           out_abort,
    output logic           busy,
    output logic [FCW-1:0] frame_cnt,
    output logic [FCW-1:0] drop_cnt
);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_SOF, CAPTURE, SKIP, DROP} state_t;

    state_t         state_q;
    logic           fval_q;
    logic [CW-1:0]  xs_q, ys_q, w_q, h_q;
    logic [3:0]     skip_q;
    logic           stop_q;
    logic           sof_pend_q;
    logic           out_valid_q, out_sof_q, out_abort_q;
    logic [DW-1:0]  out_data_q;
    logic [FCW-1:0] frame_q, drop_q;

    logic           sof_evt, eof_evt, stop_any;
    logic [CW:0]    dx, dy;
    logic           in_win;
    logic           out_valid_d;
    logic [DW-1:0]  pix_d;

    assign sof_evt  = CAMERA_FVAL & ~fval_q;
    assign eof_evt  = ~CAMERA_FVAL & fval_q;
    assign stop_any = stop_q | cfg_stop;

    // Subtract in CW+1 bits so a pixel left of / above the origin never wraps into the window.
    always_comb begin
        dx     = {1'b0, bayer_x} - {1'b0, xs_q};
        dy     = {1'b0, bayer_y} - {1'b0, ys_q};
        in_win = (bayer_x >= xs_q) && (dx < {1'b0, w_q}) &&
                 (bayer_y >= ys_q) && (dy < {1'b0, h_q});
        // afull coinciding with eof lets the frame finish, so the last pixel still goes out.
        out_valid_d = bayer_valid && in_win && (state_q == CAPTURE) &&
                      !(fifo_afull && !eof_evt);
    end

    always_comb begin
        pix_d = bayer_data;
`ifdef BAYER_CAPTURE_TEST_PATTERN_EN
        if (cfg_pattern)
            pix_d = {bayer_x[DW/2-1:0] ^ bayer_y[DW/2-1:0], bayer_x[DW/2-1:0]};
`endif
    end

    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            fval_q      <= 1'b0;
            xs_q        <= '0;
            ys_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            skip_q      <= '0;
            stop_q      <= 1'b0;
            sof_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_abort_q <= 1'b0;
            out_data_q  <= '0;
            frame_q     <= '0;
            drop_q      <= '0;
        end else begin
            fval_q      <= CAMERA_FVAL;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_valid_d & sof_pend_q;
            out_abort_q <= 1'b0;
            if (out_valid_d) begin
                out_data_q <= pix_d;
                sof_pend_q <= 1'b0;
            end
            if (cfg_stop)
                stop_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    stop_q <= 1'b0;
                    if (cfg_start && !cfg_stop)
                        state_q <= ARM;
                end
                ARM: begin
                    if (cfg_stop) begin
                        state_q <= IDLE;
                        stop_q  <= 1'b0;
                    end else if (!CAMERA_FVAL) begin
                        state_q <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (cfg_stop) begin
                        state_q <= IDLE;
                        stop_q  <= 1'b0;
                    end else if (sof_evt) begin
                        xs_q <= cfg_x_start;
                        ys_q <= cfg_y_start;
                        w_q  <= cfg_width;
                        h_q  <= cfg_height;
                        if (skip_q == '0) begin
                            state_q    <= CAPTURE;
                            skip_q     <= cfg_skip;
                            sof_pend_q <= 1'b1;
                        end else begin
                            state_q <= SKIP;
                            skip_q  <= skip_q - 4'd1;
                        end
                    end
                end
                CAPTURE: begin
                    if (eof_evt) begin
                        frame_q <= frame_q + FCW'(1);
                        if (cfg_single || stop_any) begin
                            state_q <= IDLE;
                            stop_q  <= 1'b0;
                        end else begin
                            state_q <= WAIT_SOF;
                        end
                    end else if (fifo_afull) begin
                        state_q     <= DROP;
                        out_abort_q <= 1'b1;
                        drop_q      <= drop_q + FCW'(1);
                    end
                end
                SKIP: begin
                    if (eof_evt) begin
                        if (stop_any) begin
                            state_q <= IDLE;
                            stop_q  <= 1'b0;
                        end else begin
                            state_q <= WAIT_SOF;
                        end
                    end
                end
                DROP: begin
                    if (eof_evt) begin
                        if (cfg_single || stop_any) begin
                            state_q <= IDLE;
                            stop_q  <= 1'b0;
                        end else begin
                            state_q <= WAIT_SOF;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_abort = out_abort_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_bayer_capture_ctrl.sv
// Self-checking bench for bayer_capture_ctrl: random frames checked against a frame-level
// reference model (arm/skip/single/stop decided per frame, expected pixels queued per frame).
module tb_bayer_capture_ctrl;

    localparam int DW   = 12;
    localparam int CW   = 12;
    localparam int FCW  = 16;
    localparam int NOAF = 1 << 30;

    logic           clk;
    logic           reset_n;
    logic           CAMERA_FVAL;
    logic [CW-1:0]  bayer_x, bayer_y;
    logic [DW-1:0]  bayer_data;
    logic           bayer_valid;
    logic           cfg_start, cfg_stop, cfg_single;
    logic [3:0]     cfg_skip;
    logic [CW-1:0]  cfg_x_start, cfg_y_start, cfg_width, cfg_height;
`ifdef BAYER_CAPTURE_TEST_PATTERN_EN
    logic           cfg_pattern;
`endif
    logic           fifo_afull;
    logic [DW-1:0]  out_data;
    logic           out_valid, out_sof, out_abort, busy;
    logic [FCW-1:0] frame_cnt, drop_cnt;

    bayer_capture_ctrl #(.DW(DW), .CW(CW), .FCW(FCW)) dut (
        .CAMERA_PIXCLK (clk),
        .reset_n       (reset_n),
        .CAMERA_FVAL   (CAMERA_FVAL),
        .bayer_x       (bayer_x),
        .bayer_y       (bayer_y),
        .bayer_data    (bayer_data),
        .bayer_valid   (bayer_valid),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_single    (cfg_single),
        .cfg_skip      (cfg_skip),
        .cfg_x_start   (cfg_x_start),
        .cfg_y_start   (cfg_y_start),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
`ifdef BAYER_CAPTURE_TEST_PATTERN_EN
        .cfg_pattern   (cfg_pattern),
`endif
        .fifo_afull    (fifo_afull),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_sof       (out_sof),
        .out_abort     (out_abort),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model state
    bit          m_armed;
    int          m_skip, m_frame, m_drop;
    logic [DW:0] exp_q[$];
    logic [DW:0] obs_q[$];
    int          abort_seen, stray_sof;

    always @(negedge clk) begin
        if (out_valid) obs_q.push_back({out_sof, out_data});
        else if (out_sof) stray_sof++;
        if (out_abort) abort_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pix_model(input int x, input int y, input logic [DW-1:0] d);
`ifdef BAYER_CAPTURE_TEST_PATTERN_EN
        int m;
        m = (1 << (DW / 2)) - 1;
        if (cfg_pattern) return DW'((((x ^ y) & m) << (DW / 2)) | (x & m));
`endif
        return d;
    endfunction

    task automatic set_win(input int xs, input int ys, input int w, input int h);
        cfg_x_start = CW'(xs);
        cfg_y_start = CW'(ys);
        cfg_width   = CW'(w);
        cfg_height  = CW'(h);
    endtask

    task automatic gap(input int cyc, input bit do_stop, input bit do_start);
        CAMERA_FVAL = 1'b0;
        bayer_valid = 1'b0;
        repeat (cyc) tick();
        if (do_stop) begin
            cfg_stop = 1'b1; m_armed = 1'b0; tick();
            cfg_stop = 1'b0; tick();
        end
        if (do_start) begin
            cfg_start = 1'b1; m_armed = 1'b1; tick();
            cfg_start = 1'b0;
        end
        repeat (4) tick();
    endtask

    // mid_evt: 0 none, 1 cfg_start pulse, 2 cfg_stop pulse, 3 reset, at raster pixel mid_at
    task automatic run_frame(input int W, input int H, input bit tail, input int afull_at,
                             input int mid_evt, input int mid_at);
        int xs, ys, w, h, n, p, kind;
        bit dropped, pushed_prev, first;
        logic [CW-1:0] sv_xs, sv_ys, sv_w, sv_h;
        logic [DW-1:0] d;
        sv_xs = cfg_x_start; sv_ys = cfg_y_start; sv_w = cfg_width; sv_h = cfg_height;
        xs = int'(sv_xs); ys = int'(sv_ys); w = int'(sv_w); h = int'(sv_h);
        n = W * H; p = 0; first = 1'b1; pushed_prev = 1'b0;
        kind = 0;
        if (m_armed) begin
            if (m_skip == 0) begin kind = 1; m_skip = int'(cfg_skip); end
            else begin kind = 2; m_skip = m_skip - 1; end
        end
        dropped = (kind == 1) && (afull_at < n) && !(tail && afull_at == n - 1);

        CAMERA_FVAL = 1'b1; bayer_valid = 1'b0;
        tick(); tick();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if ($urandom_range(3) == 0) begin
                    bayer_valid = 1'b0;
                    bayer_x = CW'($urandom); bayer_y = CW'($urandom); bayer_data = DW'($urandom);
                    tick();
                    pushed_prev = 1'b0;
                end
                if (mid_evt == 3 && p == mid_at) begin
                    if (pushed_prev) void'(exp_q.pop_back());
                    bayer_valid = 1'b0;
                    reset_n = 1'b0;
                    #1;
                    check("rst_out_valid", 32'(out_valid), 0);
                    check("rst_out_sof", 32'(out_sof), 0);
                    check("rst_out_abort", 32'(out_abort), 0);
                    check("rst_out_data", 32'(out_data), 0);
                    check("rst_busy", 32'(busy), 0);
                    check("rst_frame_cnt", 32'(frame_cnt), 0);
                    check("rst_drop_cnt", 32'(drop_cnt), 0);
                    m_armed = 1'b0; m_skip = 0; m_frame = 0; m_drop = 0;
                    kind = 0; dropped = 1'b0;
                    tick(); tick();
                    reset_n = 1'b1;
                end
                if (mid_evt == 1 && p == mid_at) begin cfg_start = 1'b1; m_armed = 1'b1; end
                if (mid_evt == 2 && p == mid_at) begin cfg_stop = 1'b1; m_armed = 1'b0; end
                if (p == afull_at) fifo_afull = 1'b1;
                if (tail && p == n - 1) CAMERA_FVAL = 1'b0;
                d = DW'($urandom);
                bayer_x = CW'(x); bayer_y = CW'(y); bayer_data = d; bayer_valid = 1'b1;
                pushed_prev = 1'b0;
                if (kind == 1 && x >= xs && x - xs < w && y >= ys && y - ys < h &&
                    !(dropped && p >= afull_at)) begin
                    exp_q.push_back({first, pix_model(x, y, d)});
                    first = 1'b0;
                    pushed_prev = 1'b1;
                end
                if (p == n / 2)
                    set_win($urandom_range(0, 10), $urandom_range(0, 10),
                            $urandom_range(0, 10), $urandom_range(0, 10));
                if (tail && p == n - 1) begin
                    @(negedge clk);
                    check("busy_at_eof", 32'(busy), 32'((kind != 0) || (mid_evt == 1)));
                end
                tick();
                cfg_start = 1'b0; cfg_stop = 1'b0;
                p++;
            end
        end
        bayer_valid = 1'b0;
        if (!tail) begin
            tick();
            CAMERA_FVAL = 1'b0;
            @(negedge clk);
            check("busy_at_eof", 32'(busy), 32'((kind != 0) || (mid_evt == 1)));
            tick();
        end
        fifo_afull = 1'b0;
        if (kind == 1) begin
            if (dropped) m_drop++; else m_frame++;
            if (cfg_single) m_armed = 1'b0;
        end
        @(negedge clk);
        check("busy_after_eof", 32'(busy), 32'(m_armed));
        tick(); tick();

        check("pix_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check("pix_sof_data", 32'(obs_q[i]), 32'(exp_q[i]));
        check("abort_pulses", abort_seen, 32'(dropped));
        check("stray_sof", stray_sof, 0);
        check("frame_cnt", 32'(frame_cnt), 32'(m_frame & 16'hFFFF));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop & 16'hFFFF));
        obs_q.delete(); exp_q.delete();
        abort_seen = 0; stray_sof = 0;
        cfg_x_start = sv_xs; cfg_y_start = sv_ys; cfg_width = sv_w; cfg_height = sv_h;
    endtask

    initial begin
        int W, H, r, base;
        reset_n = 1'b0; CAMERA_FVAL = 1'b0; bayer_valid = 1'b0;
        bayer_x = '0; bayer_y = '0; bayer_data = '0;
        cfg_start = 1'b0; cfg_stop = 1'b0; cfg_single = 1'b0; cfg_skip = '0;
        set_win(2, 1, 4, 3);
`ifdef BAYER_CAPTURE_TEST_PATTERN_EN
        cfg_pattern = 1'b0;
`endif
        fifo_afull = 1'b0;
        m_armed = 1'b0; m_skip = 0; m_frame = 0; m_drop = 0;
        abort_seen = 0; stray_sof = 0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_sof", 32'(out_sof), 0);
        check("reset_out_abort", 32'(out_abort), 0);
        check("reset_out_data", 32'(out_data), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_frame_cnt", 32'(frame_cnt), 0);
        check("reset_drop_cnt", 32'(drop_cnt), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Continuous capture, window (2,1,4,3) on 8x4 frames
        gap(3, 1'b0, 1'b1);
        repeat (3) run_frame(8, 4, 1'b0, NOAF, 0, 0);

        // Start mid-frame: that frame is not captured, the next one is from origin (0,0)
        gap(3, 1'b1, 1'b0);
        set_win(0, 0, 4, 2);
        run_frame(8, 4, 1'b0, NOAF, 1, 13);
        run_frame(8, 4, 1'b1, NOAF, 0, 0);

        // Decimation: skip=2 over 6 frames captures frames 1 and 4
        gap(3, 1'b1, 1'b0);
        cfg_skip = 4'd2;
        set_win(2, 1, 4, 3);
        gap(2, 1'b0, 1'b1);
        base = m_frame;
        for (int i = 0; i < 6; i++) run_frame(8, 4, 1'($urandom_range(1)), NOAF, 0, 0);
        check("skip2_frames", 32'(frame_cnt), 32'(base + 2));

        // Back-pressure at the 6th window pixel, then a clean frame
        gap(3, 1'b1, 1'b0);
        cfg_skip = 4'd0;
        gap(2, 1'b0, 1'b1);
        run_frame(8, 4, 1'b0, 19, 0, 0);
        run_frame(8, 4, 1'b0, NOAF, 0, 0);
        // afull only in the eof cycle: frame completes
        run_frame(8, 4, 1'b1, 31, 0, 0);
        // empty window still counts
        set_win(2, 1, 0, 3);
        run_frame(8, 4, 1'b0, NOAF, 0, 0);
        set_win(2, 1, 4, 3);

        // Single shot
        gap(3, 1'b1, 1'b0);
        cfg_single = 1'b1;
        gap(2, 1'b0, 1'b1);
        run_frame(8, 4, 1'b1, NOAF, 0, 0);
        run_frame(8, 4, 1'b0, NOAF, 0, 0);
        cfg_single = 1'b0;

        // Reset in the middle of a captured frame
        gap(3, 1'b0, 1'b1);
        run_frame(8, 4, 1'b0, NOAF, 0, 0);
        run_frame(8, 4, 1'b0, NOAF, 3, 20);
        run_frame(8, 4, 1'b0, NOAF, 0, 0);

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            W = $urandom_range(1, 10);
            H = $urandom_range(1, 6);
            r = $urandom_range(9);
            set_win($urandom_range(0, W), $urandom_range(0, H),
                    $urandom_range(0, W), $urandom_range(0, H));
            cfg_skip   = 4'($urandom_range(0, 3));
            cfg_single = ($urandom_range(4) == 0);
`ifdef BAYER_CAPTURE_TEST_PATTERN_EN
            cfg_pattern = 1'($urandom_range(1));
`endif
            gap($urandom_range(1, 4), r == 0, r <= 4);
            run_frame(W, H, 1'($urandom_range(1)),
                      ($urandom_range(2) == 0) ? $urandom_range(0, W * H - 1) : NOAF,
                      (r == 9) ? 1 : ((r == 8) ? 2 : 0), $urandom_range(0, W * H - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
